sub_bytes: RTL

SUB_BYTES -- requirements
Module: sub_bytes

---
 rtl/sub_bytes.sv | 98 +++++++++
 1 files changed

// File: rtl/sub_bytes.sv
// AES SubBytes engine: latches a 128-bit state and substitutes
// one 32-bit column per cycle through the forward S-box.
module sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    output logic         finish,
    output logic [127:0] subbytes
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic   [1:0]   r_col;
    logic   [127:0] r_in;
    logic   [31:0]  w_col;
    logic   [31:0]  w_sub;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        logic [7:0] s;
        t = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
              ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    assign w_col = r_in[{r_col, 5'd0} +: 32];
    assign w_sub = {sbox(w_col[31:24]), sbox(w_col[23:16]),
                    sbox(w_col[15:8]),  sbox(w_col[7:0])};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; dropping start always returns to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = BUSY;
            BUSY: begin
                if (!start)            w_next = IDLE;
                else if (r_col == 2'd3) w_next = DONE;
            end
            DONE: if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch input, write one substituted column per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= 2'd0;
            r_in     <= '0;
            subbytes <= '0;
            finish   <= 1'b0;
        end else begin
            finish <= (w_next == DONE);
            if (r_state == IDLE && start) begin
                r_in  <= in;
                r_col <= 2'd0;
            end else if (r_state == BUSY && start) begin
                subbytes[{r_col, 5'd0} +: 32] <= w_sub;
                r_col <= r_col + 2'd1;
            end
        end
    end

endmodule
